tl_a_param_queue: RTL and testbench

TL_A_PARAM_QUEUE -- requirements
Module: tl_a_param_queue

---
 rtl/tl_pkg.sv | 35 +++
 rtl/tl_a_queue_ram.sv | 27 ++
 rtl/tl_a_param_queue.sv | 135 +++++++++++++
 tb/tb_tl_a_param_queue.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// Shared TileLink channel-A definitions: opcode/param encodings, default field widths
// and the packed-beat width helper used by queue storage.
package tl_pkg;

    localparam int TL_OPCODE_W = 3;
    localparam int TL_PARAM_W  = 3;
    localparam int TL_SIZE_W   = 4;
    localparam int TL_SOURCE_W = 8;
    localparam int TL_ADDR_W   = 31;
    localparam int TL_DATA_W   = 64;

    typedef enum logic [2:0] {
        A_PUT_FULL_DATA    = 3'd0,
        A_PUT_PARTIAL_DATA = 3'd1,
        A_ARITHMETIC_DATA  = 3'd2,
        A_LOGICAL_DATA     = 3'd3,
        A_GET              = 3'd4,
        A_INTENT           = 3'd5,
        A_ACQUIRE_BLOCK    = 3'd6,
        A_ACQUIRE_PERM     = 3'd7
    } tl_a_opcode_e;

    typedef enum logic [2:0] {
        GROW_NTOB = 3'd0,
        GROW_NTOT = 3'd1,
        GROW_BTOT = 3'd2
    } tl_a_grow_param_e;

    // Packed beat is {corrupt, data, mask, address, source, size, param, opcode}.
    function automatic int tl_a_beat_w(input int size_w, input int source_w,
                                       input int addr_w, input int data_w);
        return TL_OPCODE_W + TL_PARAM_W + size_w + source_w + addr_w + data_w / 8 + data_w + 1;
    endfunction

endpackage

// File: rtl/tl_a_queue_ram.sv
// Queue storage: DEPTH x WIDTH register array, one synchronous write port and one
// combinational read port.
module tl_a_queue_ram #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8,
    parameter int PTR_W = 1
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [PTR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [PTR_W-1:0] i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // NOTE: the array is deliberately not reset; pointer state alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/tl_a_param_queue.sv
// TileLink channel-A beat queue with optional flow-through (FLOW) and accept-while-full (PIPE).
// Occupancy comes from wrap-at-DEPTH pointers plus maybe_full, so DEPTH need not be a power of two.
module tl_a_param_queue
    import tl_pkg::*;
#(
    parameter int  DEPTH    = 2,
    parameter int  SIZE_W   = TL_SIZE_W,
    parameter int  SOURCE_W = TL_SOURCE_W,
    parameter int  ADDR_W   = TL_ADDR_W,
    parameter int  DATA_W   = TL_DATA_W,
    parameter int  FLOW     = 0,
    parameter int  PIPE     = 0,
    localparam int MASK_W   = DATA_W / 8,
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                io_enq_valid,
    output logic                io_enq_ready,
    input  logic [2:0]          io_enq_bits_opcode,
    input  logic [2:0]          io_enq_bits_param,
    input  logic [SIZE_W-1:0]   io_enq_bits_size,
    input  logic [SOURCE_W-1:0] io_enq_bits_source,
    input  logic [ADDR_W-1:0]   io_enq_bits_address,
    input  logic [MASK_W-1:0]   io_enq_bits_mask,
    input  logic [DATA_W-1:0]   io_enq_bits_data,
    input  logic                io_enq_bits_corrupt,
    output logic                io_deq_valid,
    input  logic                io_deq_ready,
    output logic [2:0]          io_deq_bits_opcode,
    output logic [2:0]          io_deq_bits_param,
    output logic [SIZE_W-1:0]   io_deq_bits_size,
    output logic [SOURCE_W-1:0] io_deq_bits_source,
    output logic [ADDR_W-1:0]   io_deq_bits_address,
    output logic [MASK_W-1:0]   io_deq_bits_mask,
    output logic [DATA_W-1:0]   io_deq_bits_data,
    output logic                io_deq_bits_corrupt,
    output logic [CNT_W-1:0]    io_count
);

    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int               BEAT_W   = tl_a_beat_w(SIZE_W, SOURCE_W, ADDR_W, DATA_W);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0]  r_enq_ptr;
    logic [PTR_W-1:0]  r_deq_ptr;
    logic              r_maybe_full;
    logic              w_ptr_match;
    logic              w_empty;
    logic              w_full;
    logic              w_do_enq;
    logic              w_do_deq;
    logic              w_bypass;
    logic [BEAT_W-1:0] w_enq_beat;
    logic [BEAT_W-1:0] w_ram_beat;
    logic [BEAT_W-1:0] w_deq_beat;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_ptr_match  = (r_enq_ptr == r_deq_ptr);
    assign w_empty      = w_ptr_match & ~r_maybe_full;
    assign w_full       = w_ptr_match &  r_maybe_full;
    assign w_bypass     = (FLOW != 0) & w_empty;
    assign io_enq_ready = ~w_full | ((PIPE != 0) & io_deq_ready);
    assign io_deq_valid = ~w_empty | ((FLOW != 0) & io_enq_valid);

    // NOTE: both outputs get their default first, so no branch can leave one unassigned and infer a latch.
    always_comb begin
        w_do_enq = io_enq_valid & io_enq_ready;
        w_do_deq = io_deq_valid & io_deq_ready;
        if (w_bypass) begin
            // An empty flow-through queue hands the beat straight to deq without storing it.
            w_do_deq = 1'b0;
            if (io_deq_ready) begin
                w_do_enq = 1'b0;
            end
        end
    end

    // NOTE: non-blocking assignments here so every flop samples the pre-edge value of its peers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_enq_ptr    <= '0;
            r_deq_ptr    <= '0;
            r_maybe_full <= 1'b0;
        end else begin
            if (w_do_enq) begin
                r_enq_ptr <= next_ptr(r_enq_ptr);
            end
            if (w_do_deq) begin
                r_deq_ptr <= next_ptr(r_deq_ptr);
            end
            if (w_do_enq != w_do_deq) begin
                r_maybe_full <= w_do_enq;
            end
        end
    end

    // Wrapped difference computed explicitly, since DEPTH may not be a power of two.
    always_comb begin
        if (w_full) begin
            io_count = CNT_W'(DEPTH);
        end else if (r_enq_ptr >= r_deq_ptr) begin
            io_count = CNT_W'(r_enq_ptr - r_deq_ptr);
        end else begin
            io_count = CNT_W'(DEPTH - int'(r_deq_ptr) + int'(r_enq_ptr));
        end
    end

    assign w_enq_beat = {io_enq_bits_corrupt, io_enq_bits_data, io_enq_bits_mask,
                         io_enq_bits_address, io_enq_bits_source, io_enq_bits_size,
                         io_enq_bits_param, io_enq_bits_opcode};

    tl_a_queue_ram #(
        .DEPTH (DEPTH),
        .WIDTH (BEAT_W),
        .PTR_W (PTR_W)
    ) u_ram (
        .clk     (clock),
        .i_we    (w_do_enq),
        .i_waddr (r_enq_ptr),
        .i_wdata (w_enq_beat),
        .i_raddr (r_deq_ptr),
        .o_rdata (w_ram_beat)
    );

    assign w_deq_beat = w_bypass ? w_enq_beat : w_ram_beat;

    assign {io_deq_bits_corrupt, io_deq_bits_data, io_deq_bits_mask,
            io_deq_bits_address, io_deq_bits_source, io_deq_bits_size,
            io_deq_bits_param, io_deq_bits_opcode} = w_deq_beat;

endmodule

// File: tb/tb_tl_a_param_queue.sv
// Bench for tl_a_param_queue: a DEPTH=3 vector table plus hand sequences for flow-through,
// pipelined-full, asynchronous reset mid-operation and a DEPTH=1 / 32-bit-data queue.
module tb_tl_a_param_queue;
    import tl_pkg::*;

    localparam int BW   = 122;  // default widths: 3+3+4+8+31+8+64+1
    localparam int BW32 = 86;   // DATA_W=32:      3+3+4+8+31+4+32+1

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    // Bench-side beat layout {corrupt, data, mask, address, source, size, param, opcode}.
    function automatic logic [BW-1:0] mk_beat(input logic [7:0] s);
        logic [63:0] d;
        d = {8{s}} ^ 64'h0123_4567_89AB_CDEF;
        return {s[0], d, s ^ 8'hA5, {s[6:0], 24'hC0FFEE}, s, s[3:0], s[6:4], s[2:0]};
    endfunction

    function automatic logic [BW32-1:0] mk_beat32(input logic [7:0] s);
        logic [31:0] d;
        d = {4{s}} ^ 32'h89AB_CDEF;
        return {s[0], d, s[3:0] ^ 4'h5, {s[6:0], 24'hBADF00}, s, s[3:0], s[6:4], s[2:0]};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    logic d3_ev, d3_dr;  logic [BW-1:0]   d3_enq;  wire [BW-1:0]   d3_deq;  wire d3_er, d3_dv;  wire [1:0] d3_cnt;
    logic fl_ev, fl_dr;  logic [BW-1:0]   fl_enq;  wire [BW-1:0]   fl_deq;  wire fl_er, fl_dv;  wire [1:0] fl_cnt;
    logic pp_ev, pp_dr;  logic [BW-1:0]   pp_enq;  wire [BW-1:0]   pp_deq;  wire pp_er, pp_dv;  wire [1:0] pp_cnt;
    logic d1_ev, d1_dr;  logic [BW32-1:0] d1_enq;  wire [BW32-1:0] d1_deq;  wire d1_er, d1_dv;  wire      d1_cnt;

    tl_a_param_queue #(.DEPTH(3)) u_d3 (
        .clock(clk), .reset(rst_n),
        .io_enq_valid(d3_ev), .io_enq_ready(d3_er),
        .io_enq_bits_opcode(d3_enq[2:0]), .io_enq_bits_param(d3_enq[5:3]), .io_enq_bits_size(d3_enq[9:6]),
        .io_enq_bits_source(d3_enq[17:10]), .io_enq_bits_address(d3_enq[48:18]), .io_enq_bits_mask(d3_enq[56:49]),
        .io_enq_bits_data(d3_enq[120:57]), .io_enq_bits_corrupt(d3_enq[121]),
        .io_deq_valid(d3_dv), .io_deq_ready(d3_dr),
        .io_deq_bits_opcode(d3_deq[2:0]), .io_deq_bits_param(d3_deq[5:3]), .io_deq_bits_size(d3_deq[9:6]),
        .io_deq_bits_source(d3_deq[17:10]), .io_deq_bits_address(d3_deq[48:18]), .io_deq_bits_mask(d3_deq[56:49]),
        .io_deq_bits_data(d3_deq[120:57]), .io_deq_bits_corrupt(d3_deq[121]),
        .io_count(d3_cnt)
    );

    tl_a_param_queue #(.DEPTH(2), .FLOW(1)) u_flow (
        .clock(clk), .reset(rst_n),
        .io_enq_valid(fl_ev), .io_enq_ready(fl_er),
        .io_enq_bits_opcode(fl_enq[2:0]), .io_enq_bits_param(fl_enq[5:3]), .io_enq_bits_size(fl_enq[9:6]),
        .io_enq_bits_source(fl_enq[17:10]), .io_enq_bits_address(fl_enq[48:18]), .io_enq_bits_mask(fl_enq[56:49]),
        .io_enq_bits_data(fl_enq[120:57]), .io_enq_bits_corrupt(fl_enq[121]),
        .io_deq_valid(fl_dv), .io_deq_ready(fl_dr),
        .io_deq_bits_opcode(fl_deq[2:0]), .io_deq_bits_param(fl_deq[5:3]), .io_deq_bits_size(fl_deq[9:6]),
        .io_deq_bits_source(fl_deq[17:10]), .io_deq_bits_address(fl_deq[48:18]), .io_deq_bits_mask(fl_deq[56:49]),
        .io_deq_bits_data(fl_deq[120:57]), .io_deq_bits_corrupt(fl_deq[121]),
        .io_count(fl_cnt)
    );

    tl_a_param_queue #(.DEPTH(2), .PIPE(1)) u_pipe (
        .clock(clk), .reset(rst_n),
        .io_enq_valid(pp_ev), .io_enq_ready(pp_er),
        .io_enq_bits_opcode(pp_enq[2:0]), .io_enq_bits_param(pp_enq[5:3]), .io_enq_bits_size(pp_enq[9:6]),
        .io_enq_bits_source(pp_enq[17:10]), .io_enq_bits_address(pp_enq[48:18]), .io_enq_bits_mask(pp_enq[56:49]),
        .io_enq_bits_data(pp_enq[120:57]), .io_enq_bits_corrupt(pp_enq[121]),
        .io_deq_valid(pp_dv), .io_deq_ready(pp_dr),
        .io_deq_bits_opcode(pp_deq[2:0]), .io_deq_bits_param(pp_deq[5:3]), .io_deq_bits_size(pp_deq[9:6]),
        .io_deq_bits_source(pp_deq[17:10]), .io_deq_bits_address(pp_deq[48:18]), .io_deq_bits_mask(pp_deq[56:49]),
        .io_deq_bits_data(pp_deq[120:57]), .io_deq_bits_corrupt(pp_deq[121]),
        .io_count(pp_cnt)
    );

    tl_a_param_queue #(.DEPTH(1), .DATA_W(32)) u_d1 (
        .clock(clk), .reset(rst_n),
        .io_enq_valid(d1_ev), .io_enq_ready(d1_er),
        .io_enq_bits_opcode(d1_enq[2:0]), .io_enq_bits_param(d1_enq[5:3]), .io_enq_bits_size(d1_enq[9:6]),
        .io_enq_bits_source(d1_enq[17:10]), .io_enq_bits_address(d1_enq[48:18]), .io_enq_bits_mask(d1_enq[52:49]),
        .io_enq_bits_data(d1_enq[84:53]), .io_enq_bits_corrupt(d1_enq[85]),
        .io_deq_valid(d1_dv), .io_deq_ready(d1_dr),
        .io_deq_bits_opcode(d1_deq[2:0]), .io_deq_bits_param(d1_deq[5:3]), .io_deq_bits_size(d1_deq[9:6]),
        .io_deq_bits_source(d1_deq[17:10]), .io_deq_bits_address(d1_deq[48:18]), .io_deq_bits_mask(d1_deq[52:49]),
        .io_deq_bits_data(d1_deq[84:53]), .io_deq_bits_corrupt(d1_deq[85]),
        .io_count(d1_cnt)
    );

    // One cycle of DEPTH=3 stimulus and the outputs expected just before the following edge.
    typedef struct {
        logic       ev;
        logic       dr;
        logic [7:0] src;
        logic       er;
        logic       dv;
        logic [1:0] cnt;
        logic [7:0] dsrc;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic ev, input logic dr, input logic [7:0] src,
                           input logic er, input logic dv, input logic [1:0] cnt, input logic [7:0] dsrc);
        vec_t v;
        v.ev = ev; v.dr = dr; v.src = src; v.er = er; v.dv = dv; v.cnt = cnt; v.dsrc = dsrc;
        vecs.push_back(v);
    endtask

    initial begin
        rst_n = 1'b0;
        d3_ev = 0; d3_dr = 0; d3_enq = '0;
        fl_ev = 0; fl_dr = 0; fl_enq = '0;
        pp_ev = 0; pp_dr = 0; pp_enq = '0;
        d1_ev = 0; d1_dr = 0; d1_enq = '0;

        @(negedge clk); #1;
        check("reset d3 enq_ready", d3_er, 1'b1);
        check("reset d3 deq_valid", d3_dv, 1'b0);
        check("reset d3 count", d3_cnt, 2'd0);
        check("reset flow deq_valid", fl_dv, 1'b0);
        check("reset pipe count", pp_cnt, 2'd0);
        check("reset d1 enq_ready", d1_er, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill to full with beat 4 held, drain in order, then ten simultaneous enq/deq cycles.
        //      ev  dr  src    er  dv  cnt  dsrc
        add_vec(1, 0, 8'h01,  1, 0, 2'd0, 8'h00);
        add_vec(1, 0, 8'h02,  1, 1, 2'd1, 8'h01);
        add_vec(1, 0, 8'h03,  1, 1, 2'd2, 8'h01);
        add_vec(1, 0, 8'h04,  0, 1, 2'd3, 8'h01);
        add_vec(1, 0, 8'h04,  0, 1, 2'd3, 8'h01);
        add_vec(1, 1, 8'h04,  0, 1, 2'd3, 8'h01);
        add_vec(1, 1, 8'h04,  1, 1, 2'd2, 8'h02);
        add_vec(0, 1, 8'h00,  1, 1, 2'd2, 8'h03);
        add_vec(0, 1, 8'h00,  1, 1, 2'd1, 8'h04);
        add_vec(0, 1, 8'h00,  1, 0, 2'd0, 8'h00);
        add_vec(1, 1, 8'h10,  1, 0, 2'd0, 8'h00);
        for (int k = 0; k < 10; k++) begin
            add_vec(1, 1, 8'h11 + 8'(k), 1, 1, 2'd1, 8'h10 + 8'(k));
        end
        add_vec(0, 1, 8'h00,  1, 1, 2'd1, 8'h1A);
        add_vec(0, 0, 8'h00,  1, 0, 2'd0, 8'h00);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            d3_ev  = vecs[i].ev;
            d3_dr  = vecs[i].dr;
            d3_enq = mk_beat(vecs[i].src);
            #1;
            check($sformatf("d3 vec %0d enq_ready", i), d3_er, vecs[i].er);
            check($sformatf("d3 vec %0d deq_valid", i), d3_dv, vecs[i].dv);
            check($sformatf("d3 vec %0d count", i), d3_cnt, vecs[i].cnt);
            if (vecs[i].dv) begin
                check($sformatf("d3 vec %0d deq beat", i), d3_deq, mk_beat(vecs[i].dsrc));
            end
        end
        d3_ev = 0; d3_dr = 0;

        // FLOW=1: empty queue passes the beat through in the same cycle without storing it.
        @(negedge clk);
        fl_enq          = mk_beat(8'h42);
        fl_enq[2:0]     = A_GET;
        fl_enq[120:57]  = 64'h0000_0000_DEAD_BEEF;
        fl_ev = 1; fl_dr = 1;
        #1;
        check("flow bypass deq_valid", fl_dv, 1'b1);
        check("flow bypass data", fl_deq[120:57], 64'h0000_0000_DEAD_BEEF);
        check("flow bypass opcode", fl_deq[2:0], A_GET);
        check("flow bypass source", fl_deq[17:10], 8'h42);
        check("flow bypass count", fl_cnt, 2'd0);
        @(negedge clk); #1;
        check("flow after bypass count", fl_cnt, 2'd0);
        fl_enq = mk_beat(8'h43); fl_dr = 0;
        #1;
        check("flow store deq_valid", fl_dv, 1'b1);
        check("flow store passthrough", fl_deq, mk_beat(8'h43));
        @(negedge clk);
        fl_ev = 0; fl_dr = 1;
        #1;
        check("flow stored count", fl_cnt, 2'd1);
        check("flow stored beat", fl_deq, mk_beat(8'h43));
        @(negedge clk);
        fl_dr = 0;
        #1;
        check("flow drained count", fl_cnt, 2'd0);
        check("flow drained deq_valid", fl_dv, 1'b0);

        // PIPE=1: full queue with deq_ready accepts a new beat in the dequeuing cycle.
        @(negedge clk); pp_ev = 1; pp_dr = 0; pp_enq = mk_beat(8'h21);
        @(negedge clk); pp_enq = mk_beat(8'h22);
        @(negedge clk); pp_enq = mk_beat(8'h23);
        #1;
        check("pipe full count", pp_cnt, 2'd2);
        check("pipe full enq_ready", pp_er, 1'b0);
        check("pipe full head", pp_deq, mk_beat(8'h21));
        pp_dr = 1;
        #1;
        check("pipe full enq_ready with deq_ready", pp_er, 1'b1);
        @(negedge clk);
        pp_ev = 0; pp_dr = 0;
        #1;
        check("pipe swap count", pp_cnt, 2'd2);
        check("pipe swap head", pp_deq, mk_beat(8'h22));

        // Asynchronous reset between edges discards the two queued beats at once.
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset count", pp_cnt, 2'd0);
        check("async reset deq_valid", pp_dv, 1'b0);
        check("async reset enq_ready", pp_er, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        pp_ev = 1; pp_enq = mk_beat(8'h33);
        @(negedge clk);
        pp_ev = 0;
        #1;
        check("post reset deq_valid", pp_dv, 1'b1);
        check("post reset first beat", pp_deq, mk_beat(8'h33));
        check("post reset count", pp_cnt, 2'd1);

        // DEPTH=1, 32-bit data: alternating enq/deq; a beat offered while full must not land.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            d1_ev = 1; d1_dr = 1; d1_enq = mk_beat32(8'h50 + 8'(k));
            #1;
            check($sformatf("d1 %0d empty enq_ready", k), d1_er, 1'b1);
            check($sformatf("d1 %0d empty deq_valid", k), d1_dv, 1'b0);
            check($sformatf("d1 %0d empty count", k), d1_cnt, 1'b0);
            @(negedge clk);
            d1_enq = mk_beat32(8'h60 + 8'(k));
            #1;
            check($sformatf("d1 %0d full enq_ready", k), d1_er, 1'b0);
            check($sformatf("d1 %0d full count", k), d1_cnt, 1'b1);
            check($sformatf("d1 %0d full beat", k), d1_deq, mk_beat32(8'h50 + 8'(k)));
        end
        @(negedge clk);
        d1_ev = 0; d1_dr = 0;
        #1;
        check("d1 final count", d1_cnt, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
